counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0: value loaded by reset and by clear, WIDTH bits.
REQ-003 Port clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port enable  input  1: count step enable, default-tied 1 (free-running when unconnected).
REQ-006 Port clear  input  1: synchronous clear to RESET_VALUE, default-tied 0.
REQ-007 Port load  input  1: synchronous load of load_value, default-tied 0.
REQ-008 Port load_value  input  WIDTH: value taken when load=1, default-tied 0.
REQ-009 Port up_down  input  1: 1 = count up, 0 = count down, default-tied 1.
REQ-010 Port count  output  WIDTH: current registered count value.
REQ-011 Port wrap  output  1: registered one-cycle pulse, high in the cycle after a wrap.
REQ-012 Port at_max  output  1: combinational, high when count == all-ones.
REQ-013 Port at_min  output  1: combinational, high when count == 0.

Function
REQ-014 Per rising edge, priority: clear > load > enable > hold.
REQ-015 clear=1: count <= RESET_VALUE; wrap <= 0.
REQ-016 load=1 (clear=0): count <= load_value; wrap <= 0.
REQ-017 enable=1, up_down=1: count <= count+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-018 enable=1, up_down=0: count <= count-1 modulo 2^WIDTH; 0 wraps to all-ones.
REQ-019 wrap <= 1 exactly when REQ-017 or REQ-018 wraps in that edge; otherwise wrap <= 0.
REQ-020 enable=0, clear=0, load=0: count and wrap hold/clear respectively (count holds, wrap <= 0).
REQ-021 Latency: count reflects any command one clock after the sampling edge; no combinational path from inputs to count or wrap.
REQ-022 Direction change takes effect on the same edge at which up_down is sampled; no turnaround cycle.
REQ-023 Simultaneous clear and load: clear wins; simultaneous load and enable: load wins, no step applied.
REQ-024 at_max and at_min derive only from count; never both high (WIDTH >= 2).

Reset
REQ-025 reset_n=0 forces count = RESET_VALUE and wrap = 0 immediately, independent of clock.
REQ-026 Reset asserted mid-operation overrides every other input for its whole duration.
REQ-027 After reset_n deasserts, the first rising edge applies normal function per REQ-014.

Structure
REQ-028 Shared package counter_pkg holds COUNTER_DEFAULT_WIDTH = 8 and a typedef for the command priority enum (CMD_CLEAR, CMD_LOAD, CMD_STEP, CMD_HOLD).
REQ-029 One sub-module counter_next_value: combinational next-count and wrap-detect logic from count, command and up_down; counter owns registers and flag outputs.
REQ-030 Single always_ff block for count and wrap; no latches; fully synthesizable.

Verification
REQ-031 reset_n=0 then release, enable=1, up_down=1, 10 clocks -> count 0,1,...,10; at_min high only at 0.
REQ-032 load_value=8'hFE, load pulse, then count up 3 clocks -> count FE, FF, 00, 01; wrap high one cycle after FF->00; at_max high at FF.
REQ-033 load 8'h01, up_down=0, 3 clocks -> 01, 00, FF, FE; wrap pulse after 00->FF.
REQ-034 clear and load both high with load_value=8'h55 -> count = RESET_VALUE (0); enable=0 for 5 clocks -> count unchanged.
REQ-035 Assert reset_n low asynchronously between edges while count=8'h37 -> count 0 and wrap 0 before next edge.
REQ-036 Free-run with defaults for 1000 clocks (10 ns period) -> count equals cycles modulo 256; wrap pulses every 256 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and command encoding for the counter
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_HOLD  = 2'd3
  } cmd_e;

  // Priority: clear over load over enable over hold.
  function automatic cmd_e decode_cmd(input logic clear, input logic load, input logic enable);
    if (clear)
      return CMD_CLEAR;
    else if (load)
      return CMD_LOAD;
    else if (enable)
      return CMD_STEP;
    else
      return CMD_HOLD;
  endfunction

endpackage

// File: rtl/counter_next_value.sv
// rtl/counter_next_value.sv - combinational next count and wrap detection
module counter_next_value
  import counter_pkg::*;
#(
  parameter int                 WIDTH       = COUNTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] count,
  input  cmd_e             cmd,
  input  logic             up_down,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap
);

  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic             wraps_up;
  logic             wraps_down;

  assign count_inc  = count + {{(WIDTH-1){1'b0}}, 1'b1};
  assign count_dec  = count - {{(WIDTH-1){1'b0}}, 1'b1};
  assign wraps_up   = &count;
  assign wraps_down = ~|count;

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    unique case (cmd)
      CMD_CLEAR: next_count = RESET_VALUE;
      CMD_LOAD:  next_count = load_value;
      CMD_STEP: begin
        if (up_down) begin
          next_count = count_inc;
          next_wrap  = wraps_up;
        end else begin
          next_count = count_dec;
          next_wrap  = wraps_down;
        end
      end
      CMD_HOLD:  next_count = count;
      default:   next_count = count;
    endcase
  end

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - up/down counter with clear, load, wrap pulse and limit flags
module counter
  import counter_pkg::*;
#(
  parameter int                 WIDTH       = COUNTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable     = 1'b1,
  input  logic             clear      = 1'b0,
  input  logic             load       = 1'b0,
  input  logic [WIDTH-1:0] load_value = '0,
  input  logic             up_down    = 1'b1,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  cmd_e             cmd;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  assign cmd = decode_cmd(clear, load, enable);

  counter_next_value #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_next_value (
    .count      (count),
    .cmd        (cmd),
    .up_down    (up_down),
    .load_value (load_value),
    .next_count (next_count),
    .next_wrap  (next_wrap)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= RESET_VALUE;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

  // Flags look only at the registered count, so they cannot both be high.
  assign at_max = &count;
  assign at_min = ~|count;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed self-checking bench for counter
module tb_counter;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       up_down;
  logic [7:0] count;
  logic       wrap;
  logic       at_max;
  logic       at_min;

  int total;
  int bad;

  counter #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .up_down    (up_down),
    .count      (count),
    .wrap       (wrap),
    .at_max     (at_max),
    .at_min     (at_min)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_state(input string tag, input logic [7:0] exp_count, input logic exp_wrap);
    check({tag, ".count"}, {24'd0, count}, {24'd0, exp_count});
    check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, exp_wrap});
    check({tag, ".at_max"}, {31'd0, at_max}, {31'd0, (exp_count == 8'hFF)});
    check({tag, ".at_min"}, {31'd0, at_min}, {31'd0, (exp_count == 8'h00)});
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    load = 1'b0;
    load_value = 8'h00;
    up_down = 1'b1;

    // Reset and count up from zero
    #12;
    check_state("reset", 8'h00, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    check_state("released", 8'h00, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check_state($sformatf("up%0d", i), i[7:0], 1'b0);
    end

    // Load FE and wrap upward
    load = 1'b1;
    load_value = 8'hFE;
    step();
    load = 1'b0;
    check_state("load_fe", 8'hFE, 1'b0);
    step();
    check_state("up_ff", 8'hFF, 1'b0);
    step();
    check_state("up_wrap_00", 8'h00, 1'b1);
    step();
    check_state("up_01", 8'h01, 1'b0);

    // Load 01 and wrap downward
    load = 1'b1;
    load_value = 8'h01;
    up_down = 1'b0;
    step();
    load = 1'b0;
    check_state("load_01", 8'h01, 1'b0);
    step();
    check_state("dn_00", 8'h00, 1'b0);
    step();
    check_state("dn_wrap_ff", 8'hFF, 1'b1);
    step();
    check_state("dn_fe", 8'hFE, 1'b0);

    // Clear beats load; load beats enable
    clear = 1'b1;
    load = 1'b1;
    load_value = 8'h55;
    step();
    check_state("clear_over_load", 8'h00, 1'b0);
    clear = 1'b0;
    load_value = 8'h37;
    up_down = 1'b1;
    step();
    check_state("load_over_step", 8'h37, 1'b0);
    load = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_state($sformatf("hold%0d", i), 8'h37, 1'b0);
    end

    // Asynchronous reset between edges overrides load
    enable = 1'b1;
    load = 1'b1;
    load_value = 8'hC3;
    #2 reset_n = 1'b0;
    #1 check_state("async_reset", 8'h00, 1'b0);
    step();
    check_state("reset_held", 8'h00, 1'b0);
    reset_n = 1'b1;
    load_value = 8'hA5;
    step();
    check_state("post_reset_load", 8'hA5, 1'b0);

    // Direction change applies on the same edge
    load = 1'b0;
    up_down = 1'b0;
    step();
    check_state("dir_down", 8'hA4, 1'b0);
    up_down = 1'b1;
    step();
    check_state("dir_up", 8'hA5, 1'b0);

    // Free run from reset for 1000 cycles
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    check_state("fr_start", 8'h00, 1'b0);
    for (int c = 1; c <= 1000; c++) begin
      step();
      check_state($sformatf("fr%0d", c), c[7:0], (c % 256) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
